// File: rtl/axi4lite_reg_adapter_if.sv
// AXI4-Lite bundle shared by the interconnect and register adapters.
// Slave modport faces the endpoint, master modport faces the initiator.
interface axi4lite_intf #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]              awprot;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [2:0]              arprot;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport slave (
        input  awaddr, awprot, awvalid,
        output awready,
        input  wdata, wstrb, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready,
        input  araddr, arprot, arvalid,
        output arready,
        output rdata, rresp, rvalid,
        input  rready
    );

    modport master (
        output awaddr, awprot, awvalid,
        input  awready,
        output wdata, wstrb, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready,
        output araddr, arprot, arvalid,
        input  arready,
        input  rdata, rresp, rvalid,
        output rready
    );
endinterface

// File: rtl/axi4lite_reg_adapter.sv
// AXI4-Lite slave to single-outstanding req/ack register bus bridge.
// Define AXI4LITE_REG_ADAPTER_TIMEOUT_EN to build the REQ timeout (SLVERR).
module axi4lite_reg_adapter #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                    clk,
    input  logic                    rst_b,
    axi4lite_intf.slave             s_axil,
    output logic                    req_valid,
    output logic                    req_write,
    output logic [ADDR_WIDTH-1:0]   req_addr,
    output logic [DATA_WIDTH-1:0]   req_wdata,
    output logic [DATA_WIDTH/8-1:0] req_wstrb,
    input  logic                    req_ack,
    input  logic [DATA_WIDTH-1:0]   req_rdata,
    input  logic                    req_err
);
    localparam int SW  = DATA_WIDTH / 8;
    localparam int LSB = $clog2(SW);
    localparam logic [ADDR_WIDTH-1:0] ALIGN =
        {{(ADDR_WIDTH-LSB){1'b1}}, {LSB{1'b0}}};
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        BRESP,
        RRESP
    } state_t;

    state_t                state;
    state_t                state_n;
    logic                  aw_held;
    logic                  w_held;
    logic                  ar_held;
    logic                  aw_held_n;
    logic                  w_held_n;
    logic                  ar_held_n;
    logic [ADDR_WIDTH-1:0] aw_addr_q;
    logic [ADDR_WIDTH-1:0] ar_addr_q;
    logic [DATA_WIDTH-1:0] w_data_q;
    logic [SW-1:0]         w_strb_q;
    logic                  last_rd;

    logic                  awready_q;
    logic                  wready_q;
    logic                  arready_q;
    logic                  bvalid_q;
    logic                  rvalid_q;
    logic [1:0]            bresp_q;
    logic [1:0]            rresp_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic                  aw_hs;
    logic                  w_hs;
    logic                  ar_hs;
    logic                  wr_elig;
    logic                  rd_elig;
    logic                  grant_rd;
    logic                  grant_wr;
    logic                  done;
    logic                  expire;
    logic [1:0]            resp;

    assign s_axil.awready = awready_q;
    assign s_axil.wready  = wready_q;
    assign s_axil.arready = arready_q;
    assign s_axil.bvalid  = bvalid_q;
    assign s_axil.bresp   = bresp_q;
    assign s_axil.rvalid  = rvalid_q;
    assign s_axil.rresp   = rresp_q;
    assign s_axil.rdata   = rdata_q;

    logic unused;
    assign unused = ^{s_axil.awprot, s_axil.arprot, TIMEOUT_CYCLES[0]};

`ifdef AXI4LITE_REG_ADAPTER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    logic [TW-1:0] to_cnt;

    // Held at zero outside REQ, so every REQ entry starts a fresh count.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            to_cnt <= '0;
        end else if (state != REQ) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + TW'(1);
        end
    end

    assign expire = (state == REQ) &&
                    (to_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
    assign expire = 1'b0;
`endif

    always_comb begin
        aw_hs    = s_axil.awvalid && awready_q;
        w_hs     = s_axil.wvalid && wready_q;
        ar_hs    = s_axil.arvalid && arready_q;
        wr_elig  = (aw_held || aw_hs) && (w_held || w_hs);
        rd_elig  = ar_held || ar_hs;
        grant_rd = (state == IDLE) && rd_elig &&
                   (!wr_elig || !last_rd);
        grant_wr = (state == IDLE) && wr_elig && !grant_rd;
        done     = (state == REQ) && (req_ack || expire);
        resp     = (req_ack && !req_err) ? OKAY : SLVERR;

        // A losing handshake is parked, so it is granted later, not lost.
        aw_held_n = (aw_held || aw_hs) && !(done && req_write);
        w_held_n  = (w_held || w_hs) && !(done && req_write);
        ar_held_n = (ar_held || ar_hs) && !grant_rd;

        state_n = state;
        unique case (state)
            IDLE: begin
                if (grant_rd || grant_wr) begin
                    state_n = REQ;
                end
            end
            REQ: begin
                if (done) begin
                    state_n = req_write ? BRESP : RRESP;
                end
            end
            BRESP: begin
                if (s_axil.bready) begin
                    state_n = IDLE;
                end
            end
            RRESP: begin
                if (s_axil.rready) begin
                    state_n = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state     <= IDLE;
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            ar_held   <= 1'b0;
            aw_addr_q <= '0;
            ar_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            last_rd   <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            arready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            bresp_q   <= OKAY;
            rresp_q   <= OKAY;
            rdata_q   <= '0;
            req_valid <= 1'b0;
            req_write <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
            req_wstrb <= '0;
        end else begin
            state     <= state_n;
            aw_held   <= aw_held_n;
            w_held    <= w_held_n;
            ar_held   <= ar_held_n;
            awready_q <= !aw_held_n;
            wready_q  <= !w_held_n;
            arready_q <= (state_n == IDLE) && !aw_held_n &&
                         !w_held_n && !ar_held_n;

            if (aw_hs) begin
                aw_addr_q <= s_axil.awaddr;
            end
            if (w_hs) begin
                w_data_q <= s_axil.wdata;
                w_strb_q <= s_axil.wstrb;
            end
            if (ar_hs) begin
                ar_addr_q <= s_axil.araddr;
            end

            if (grant_rd) begin
                req_valid <= 1'b1;
                req_write <= 1'b0;
                req_addr  <= (ar_held ? ar_addr_q : s_axil.araddr) & ALIGN;
                req_wdata <= '0;
                req_wstrb <= '0;
                last_rd   <= 1'b1;
            end else if (grant_wr) begin
                req_valid <= 1'b1;
                req_write <= 1'b1;
                req_addr  <= (aw_held ? aw_addr_q : s_axil.awaddr) & ALIGN;
                req_wdata <= w_held ? w_data_q : s_axil.wdata;
                req_wstrb <= w_held ? w_strb_q : s_axil.wstrb;
                last_rd   <= 1'b0;
            end

            if (done) begin
                req_valid <= 1'b0;
                if (req_write) begin
                    bvalid_q <= 1'b1;
                    bresp_q  <= resp;
                end else begin
                    rvalid_q <= 1'b1;
                    rresp_q  <= resp;
                    rdata_q  <= req_ack ? req_rdata : '0;
                end
            end

            if (state == BRESP && s_axil.bready) begin
                bvalid_q <= 1'b0;
            end
            if (state == RRESP && s_axil.rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_axi4lite_reg_adapter.sv
// Bench for axi4lite_reg_adapter: directed timing cases plus random traffic
// against a word-array register model and a delayed-ack peripheral.
module tb_axi4lite_reg_adapter;
    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
    } log_t;

    logic clk = 1'b0;
    logic rst_b = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    axi4lite_intf #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();
    axi4lite_intf #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) bus64 ();

    logic        req_valid;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        req_ack = 1'b0;
    logic [31:0] req_rdata = '0;
    logic        req_err = 1'b0;

    logic        v64;
    logic        w64;
    logic [31:0] a64;
    logic [63:0] wd64;
    logic [7:0]  ws64;
    logic        ack64 = 1'b0;
    logic [63:0] rd64 = '0;
    logic        err64 = 1'b0;

    axi4lite_reg_adapter #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(4)
    ) dut (
        .clk(clk), .rst_b(rst_b), .s_axil(bus),
        .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_wstrb(req_wstrb), .req_ack(req_ack),
        .req_rdata(req_rdata), .req_err(req_err)
    );

    axi4lite_reg_adapter #(
        .DATA_WIDTH(64), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(4)
    ) dut64 (
        .clk(clk), .rst_b(rst_b), .s_axil(bus64),
        .req_valid(v64), .req_write(w64),
        .req_addr(a64), .req_wdata(wd64),
        .req_wstrb(ws64), .req_ack(ack64),
        .req_rdata(rd64), .req_err(err64)
    );

    logic [31:0] periph [16];
    logic [31:0] model [16];
    int          ack_delay = 0;
    int          wait_cnt = 0;
    logic [3:0]  pidx;
    logic        chk_req = 1'b0;
    logic        exp_write;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_wstrb;
    log_t        req_log [$];

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (s[i]) r[8*i +: 8] = d[8*i +: 8];
        end
        return r;
    endfunction

    // Register-file peripheral: acks after ack_delay waiting cycles.
    always begin
        @(posedge clk);
        #1;
        req_ack = 1'b0;
        if (rst_b && req_valid) begin
            if (ack_delay >= 0 && wait_cnt >= ack_delay) begin
                pidx      = req_addr[5:2];
                req_ack   = 1'b1;
                req_err   = req_addr[7];
                req_rdata = periph[pidx];
                if (req_write && !req_err) begin
                    periph[pidx] = merge(periph[pidx], req_wdata, req_wstrb);
                end
                req_log.push_back('{req_write, req_addr});
                if (chk_req) begin
                    chk("req_write", 64'(req_write), 64'(exp_write));
                    chk("req_addr", 64'(req_addr), 64'(exp_addr));
                    chk("req_wstrb", 64'(req_wstrb), 64'(exp_wstrb));
                    if (exp_write) begin
                        chk("req_wdata", 64'(req_wdata), 64'(exp_wdata));
                    end
                end
                wait_cnt = 0;
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    task automatic issue(input bit do_ar, input logic [31:0] ara,
                         input bit do_aw, input logic [31:0] awa,
                         input bit do_w, input logic [31:0] wd,
                         input logic [3:0] ws, input int dar,
                         input int daw, input int dw);
        bit ard, awd, wdn, arg, awg, wg;
        int cyc;
        ard = !do_ar;
        awd = !do_aw;
        wdn = !do_w;
        cyc = 0;
        bus.araddr = ara;
        bus.awaddr = awa;
        bus.wdata  = wd;
        bus.wstrb  = ws;
        while (!(ard && awd && wdn) && cyc < 200) begin
            bus.arvalid = !ard && cyc >= dar;
            bus.awvalid = !awd && cyc >= daw;
            bus.wvalid  = !wdn && cyc >= dw;
            arg = bus.arvalid && bus.arready;
            awg = bus.awvalid && bus.awready;
            wg  = bus.wvalid && bus.wready;
            @(posedge clk);
            #1;
            if (arg) ard = 1'b1;
            if (awg) awd = 1'b1;
            if (wg) wdn = 1'b1;
            cyc++;
        end
        bus.arvalid = 1'b0;
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        chk("handshake_bound", 64'(cyc < 200), 64'd1);
    endtask

    task automatic get_b(input int bd, input logic [1:0] exp);
        int n;
        n = 0;
        while (!bus.bvalid && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("bvalid", 64'(bus.bvalid), 64'd1);
        chk("bresp", 64'(bus.bresp), 64'(exp));
        for (int i = 0; i < bd; i++) begin
            @(posedge clk);
            #1;
            chk("bvalid_hold", 64'(bus.bvalid), 64'd1);
            chk("bresp_hold", 64'(bus.bresp), 64'(exp));
            chk("arready_in_b", 64'(bus.arready), 64'd0);
        end
        bus.bready = 1'b1;
        @(posedge clk);
        #1;
        bus.bready = 1'b0;
        chk("bvalid_drop", 64'(bus.bvalid), 64'd0);
    endtask

    task automatic get_r(input int rd, input logic [1:0] exp,
                         input logic [31:0] data);
        int n;
        n = 0;
        while (!bus.rvalid && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("rvalid", 64'(bus.rvalid), 64'd1);
        chk("rresp", 64'(bus.rresp), 64'(exp));
        chk("rdata", 64'(bus.rdata), 64'(data));
        for (int i = 0; i < rd; i++) begin
            @(posedge clk);
            #1;
            chk("rdata_hold", 64'(bus.rdata), 64'(data));
            chk("arready_in_r", 64'(bus.arready), 64'd0);
        end
        bus.rready = 1'b1;
        @(posedge clk);
        #1;
        bus.rready = 1'b0;
        chk("rvalid_drop", 64'(bus.rvalid), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    bit          r_wr;
    bit          r_err;
    int          r_idx;
    int          n;
    logic [31:0] r_addr;
    logic [31:0] r_data;
    logic [3:0]  r_strb;

    initial begin
        for (int i = 0; i < 16; i++) begin
            periph[i] = 32'hC0DE_0000 + 32'(i);
            model[i]  = 32'hC0DE_0000 + 32'(i);
        end
        bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
        bus.bready = 1'b0; bus.araddr = '0; bus.arprot = '0;
        bus.arvalid = 1'b0; bus.rready = 1'b0;
        bus64.awaddr = '0; bus64.awprot = '0; bus64.awvalid = 1'b0;
        bus64.wdata = '0; bus64.wstrb = '0; bus64.wvalid = 1'b0;
        bus64.bready = 1'b0; bus64.araddr = '0; bus64.arprot = '0;
        bus64.arvalid = 1'b0; bus64.rready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_valid", 64'(req_valid), 64'd0);
        chk("rst_bvalid", 64'(bus.bvalid), 64'd0);
        chk("rst_rvalid", 64'(bus.rvalid), 64'd0);
        chk("rst_awready", 64'(bus.awready), 64'd0);
        chk("rst_arready", 64'(bus.arready), 64'd0);
        chk("rst_req_addr", 64'(req_addr), 64'd0);
        #1;
        rst_b = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_awready", 64'(bus.awready), 64'd1);
        chk("post_rst_wready", 64'(bus.wready), 64'd1);
        chk("post_rst_arready", 64'(bus.arready), 64'd1);

        // Simultaneous AR/AW/W: read first, then write
        ack_delay = 1;
        issue(1, 32'h2014, 1, 32'h2018, 1, 32'h1234_5678, 4'hF, 0, 0, 0);
        chk("conf_req_read", 64'(req_write), 64'd0);
        get_r(0, 2'b00, model[5]);
        get_b(0, 2'b00);
        model[6] = merge(model[6], 32'h1234_5678, 4'hF);
        chk("conf_log_n", 64'(req_log.size()), 64'd2);
        if (req_log.size() == 2) begin
            chk("conf_first_rd", 64'(req_log[0].wr), 64'd0);
            chk("conf_first_addr", 64'(req_log[0].addr), 64'h2014);
            chk("conf_second_wr", 64'(req_log[1].wr), 64'd1);
            chk("conf_second_addr", 64'(req_log[1].addr), 64'h2018);
        end

        // 64-bit read: address aligned, error and data returned
        bus64.araddr = 32'h7;
        bus64.arvalid = 1'b1;
        n = 0;
        while (!bus64.arready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        @(posedge clk);
        #1;
        bus64.arvalid = 1'b0;
        chk("r64_req_valid", 64'(v64), 64'd1);
        chk("r64_req_addr", 64'(a64), 64'd0);
        chk("r64_req_wstrb", 64'(ws64), 64'd0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        ack64 = 1'b1;
        rd64  = 64'h0123_4567_89AB_CDEF;
        err64 = 1'b1;
        @(posedge clk);
        #1;
        ack64 = 1'b0;
        err64 = 1'b0;
        chk("r64_rvalid", 64'(bus64.rvalid), 64'd1);
        chk("r64_rdata", bus64.rdata, 64'h0123_4567_89AB_CDEF);
        chk("r64_rresp", 64'(bus64.rresp), 64'd2);
        bus64.rready = 1'b1;
        @(posedge clk);
        #1;
        bus64.rready = 1'b0;
        chk("r64_rvalid_drop", 64'(bus64.rvalid), 64'd0);

        // Write timing: AW at cycle 0, W at cycle 3, ack tied high
        ack_delay = 0;
        chk_req   = 1'b1;
        exp_write = 1'b1;
        exp_addr  = 32'h1004;
        exp_wdata = 32'hA5A5_5A5A;
        exp_wstrb = 4'hF;
        issue(0, 0, 1, 32'h1004, 1, 32'hA5A5_5A5A, 4'hF, 0, 0, 3);
        chk("wt_req_valid", 64'(req_valid), 64'd1);
        chk("wt_req_addr", 64'(req_addr), 64'h1004);
        @(posedge clk);
        #1;
        chk("wt_bvalid", 64'(bus.bvalid), 64'd1);
        get_b(10, 2'b00);
        model[1] = merge(model[1], 32'hA5A5_5A5A, 4'hF);

        // Minimum read then back-to-back AR readiness
        exp_write = 1'b0;
        exp_addr  = 32'h2024;
        exp_wstrb = 4'h0;
        issue(1, 32'h2026, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("min_req_valid", 64'(req_valid), 64'd1);
        @(posedge clk);
        #1;
        chk("min_rvalid", 64'(bus.rvalid), 64'd1);
        get_r(0, 2'b00, model[9]);
        chk("b2b_arready", 64'(bus.arready), 64'd1);

        // Random traffic against the register model
        for (int t = 0; t < 40; t++) begin
            r_wr   = $urandom_range(0, 1) == 1;
            r_err  = $urandom_range(0, 3) == 0;
            r_idx  = $urandom_range(0, 15);
            r_addr = 32'h2000 | (r_err ? 32'h80 : 32'h0) |
                     32'(r_idx << 2) | 32'($urandom_range(0, 3));
            ack_delay = $urandom_range(0, 3);
            exp_write = r_wr;
            exp_addr  = r_addr & ~32'h3;
            if (r_wr) begin
                r_data    = $urandom;
                r_strb    = 4'($urandom_range(0, 15));
                exp_wdata = r_data;
                exp_wstrb = r_strb;
                issue(0, 0, 1, r_addr, 1, r_data, r_strb, 0,
                      $urandom_range(0, 3), $urandom_range(0, 3));
                get_b($urandom_range(0, 3), r_err ? 2'b10 : 2'b00);
                if (!r_err) model[r_idx] = merge(model[r_idx], r_data, r_strb);
            end else begin
                exp_wstrb = 4'h0;
                issue(1, r_addr, 0, 0, 0, 0, 0,
                      $urandom_range(0, 3), 0, 0);
                get_r($urandom_range(0, 3), r_err ? 2'b10 : 2'b00,
                      model[r_idx]);
            end
        end
        chk_req = 1'b0;

        // No ack: timeout or indefinite wait
        ack_delay = -1;
        issue(1, 32'h2008, 0, 0, 0, 0, 0, 0, 0, 0);
        n = 0;
`ifdef AXI4LITE_REG_ADAPTER_TIMEOUT_EN
        while (req_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("timeout_len", 64'(n), 64'd4);
        get_r(0, 2'b10, 32'h0);
`else
        while (req_valid && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("no_timeout_len", 64'(n), 64'd1000);
        chk("no_timeout_valid", 64'(req_valid), 64'd1);
        ack_delay = 0;
        get_r(0, 2'b00, model[2]);
`endif

        // Reset during REQ abandons the request
        ack_delay = -1;
        issue(1, 32'h200C, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("mid_req_valid", 64'(req_valid), 64'd1);
        @(posedge clk);
        #3;
        rst_b = 1'b0;
        #1;
        chk("mid_rst_req_valid", 64'(req_valid), 64'd0);
        chk("mid_rst_bvalid", 64'(bus.bvalid), 64'd0);
        chk("mid_rst_rvalid", 64'(bus.rvalid), 64'd0);
        @(posedge clk);
        #2;
        rst_b = 1'b1;
        ack_delay = 1;
        issue(1, 32'h2030, 0, 0, 0, 0, 0, 0, 0, 0);
        get_r(1, 2'b00, model[12]);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
